// File: rtl/def_cmd_sched.sv
// Command scheduler: decodes a 4-word NIOS window and feeds two paced
// valid/ready channels from per-channel show-ahead FIFOs.

module def_cmd_sched_ch #(
    parameter int DEPTH = 8,
    parameter int GAP   = 16,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_wr,
    input  logic                       i_flush,
    input  logic [DW-1:0]              i_data,
    input  logic                       i_ready,
    output logic [DW-1:0]              o_data,
    output logic                       o_valid,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_drop,
    output logic                       o_busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CW-1:0] GAP_LD = CW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {S_EMPTY, S_PRESENT, S_GAP} state_t;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [LW-1:0] r_level;
    logic [CW-1:0] r_cnt;
    logic          r_valid;
    state_t        r_state;

    logic          w_pop, w_full, w_acc;
    logic [LW-1:0] w_level_nxt;

    assign w_pop  = r_valid & i_ready;
    assign w_full = (r_level == LW'(DEPTH));
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign w_acc  = i_wr & ~i_flush & (~w_full | w_pop);
    assign w_level_nxt = i_flush ? '0 : r_level + LW'(w_acc) - LW'(w_pop);

    always_ff @(posedge clk) begin
        if (w_acc) r_mem[r_wptr] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            r_wptr  <= r_wptr + AW'(w_acc);
            r_rptr  <= r_rptr + AW'(w_pop);
            r_level <= w_level_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_EMPTY;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_level_nxt != '0) begin
                        r_state <= S_PRESENT;
                        r_valid <= 1'b1;
                    end
                end
                S_PRESENT: begin
                    if (i_flush) begin
                        r_state <= S_EMPTY;
                        r_valid <= 1'b0;
                    end else if (w_pop) begin
                        if (GAP > 0) begin
                            r_state <= S_GAP;
                            r_valid <= 1'b0;
                            r_cnt   <= GAP_LD;
                        end else if (w_level_nxt == '0) begin
                            r_state <= S_EMPTY;
                            r_valid <= 1'b0;
                        end
                    end
                end
                S_GAP: begin
                    // Gap runs to completion even across a flush.
                    if (r_cnt == '0) begin
                        r_state <= (w_level_nxt != '0) ? S_PRESENT : S_EMPTY;
                        r_valid <= (w_level_nxt != '0);
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_EMPTY;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_data  = r_valid ? r_mem[r_rptr] : '0;
    assign o_valid = r_valid;
    assign o_level = r_level;
    assign o_drop  = i_wr & ~i_flush & ~w_acc;
    assign o_busy  = (r_level != '0) | (r_state == S_GAP);
endmodule

module def_cmd_sched #(
    parameter int         DEPTH     = 8,
    parameter logic [7:0] BASE_ADDR = 8'h20,
    parameter int         GAP       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_cmd_wr,
    input  logic [7:0]             i_cmd_addr,
    input  logic [31:0]            i_cmd_data,
    output logic [31:0]            o_cntr0_data,
    output logic                   o_cntr0_valid,
    input  logic                   i_cntr0_ready,
    output logic [31:0]            o_cntr1_data,
    output logic                   o_cntr1_valid,
    input  logic                   i_cntr1_ready,
    output logic [$clog2(DEPTH):0] o_level0,
    output logic [$clog2(DEPTH):0] o_level1,
    output logic [1:0]             o_ovf,
    output logic                   o_busy
);
    localparam int NUM_LANES = 2;
    localparam int LW        = $clog2(DEPTH) + 1;

    logic [7:0]                     w_off;
    logic                           w_hit, w_ctl, w_clr;
    logic [NUM_LANES-1:0]           w_wr, w_flush, w_drop, w_busy, w_valid, w_ready;
    logic [NUM_LANES-1:0][31:0]     w_data;
    logic [NUM_LANES-1:0][LW-1:0]   w_level;
    logic [NUM_LANES-1:0]           r_ovf;

    assign w_off   = i_cmd_addr - BASE_ADDR;
    assign w_hit   = i_cmd_wr & (w_off[7:2] == 6'd0);
    // Offset 2 is broadcast: each lane decides acceptance on its own.
    assign w_wr[0] = w_hit & ((w_off[1:0] == 2'd0) | (w_off[1:0] == 2'd2));
    assign w_wr[1] = w_hit & ((w_off[1:0] == 2'd1) | (w_off[1:0] == 2'd2));
    assign w_ctl   = w_hit & (w_off[1:0] == 2'd3);
    assign w_flush = {NUM_LANES{w_ctl}} & i_cmd_data[NUM_LANES-1:0];
    assign w_clr   = w_ctl & i_cmd_data[2];
    assign w_ready = {i_cntr1_ready, i_cntr0_ready};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        def_cmd_sched_ch #(.DEPTH(DEPTH), .GAP(GAP), .DW(32)) u_ch (
            .clk     (clk),
            .reset   (reset),
            .i_wr    (w_wr[g]),
            .i_flush (w_flush[g]),
            .i_data  (i_cmd_data),
            .i_ready (w_ready[g]),
            .o_data  (w_data[g]),
            .o_valid (w_valid[g]),
            .o_level (w_level[g]),
            .o_drop  (w_drop[g]),
            .o_busy  (w_busy[g])
        );

        // Set beats clear in the same cycle.
        always_ff @(posedge clk) begin
            if (reset)          r_ovf[g] <= 1'b0;
            else if (w_drop[g]) r_ovf[g] <= 1'b1;
            else if (w_clr)     r_ovf[g] <= 1'b0;
        end
    end

    assign o_cntr0_data  = w_data[0];
    assign o_cntr0_valid = w_valid[0];
    assign o_cntr1_data  = w_data[1];
    assign o_cntr1_valid = w_valid[1];
    assign o_level0      = w_level[0];
    assign o_level1      = w_level[1];
    assign o_ovf         = r_ovf;
    assign o_busy        = |w_busy;
endmodule
